// File: rtl/data_mem_responder_if.sv
// Valid/ready request and response channels between the CPU data port and the
// data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Handshaked data-segment RAM: accepts one load/store at a time, waits a
// programmable number of cycles, then answers with read data or an error flag.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             addr_err;
  logic [IDX_W-1:0] index;
  logic             access_now;
  logic             unused_offset_bits;

  // The lower-bound test keeps addresses below the base from wrapping into range.
  assign offset             = lat_addr - BASE_ADDR;
  assign addr_err           = (lat_addr < BASE_ADDR) || (offset >= SPAN) || (lat_addr[1:0] != 2'b00);
  assign index              = offset[IDX_W+1:2];
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};
  assign access_now         = (state == S_WAIT) && (cnt == 4'd0);

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // RAM contents survive reset, but a reset on the access edge blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && access_now && lat_we && !addr_err) begin
      mem[index] <= lat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_we      <= bus.req_we;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            cnt         <= WAIT_INIT;
            req_ready_q <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
            if (addr_err) begin
              resp_rdata_q <= 32'd0;
              resp_err_q   <= 1'b1;
            end else if (lat_we) begin
              resp_rdata_q <= 32'd0;
              resp_err_q   <= 1'b0;
            end else begin
              resp_rdata_q <= mem[index];
              resp_err_q   <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a WAIT_STATES=2 and a WAIT_STATES=0 responder driven by
// directed and random traffic, checked against an array-based memory model.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept_cycle;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus_a ();
  data_mem_responder_if bus_b ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  int          rr_mode [2];
  exp_t        exp_q_a [$];
  exp_t        exp_q_b [$];
  exp_t        cur [2];
  bit          in_resp [2];
  bit          post_hs [2];
  int          hs_cycle [2];
  logic [31:0] model_mem [2][DEPTH];

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int ws(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Reference rules in 64-bit arithmetic so nothing can wrap.
  function automatic bit model_err(input logic [31:0] addr);
    longint a;
    a = longint'({32'h0, addr});
    return (a < longint'({32'h0, BASE})) || (a >= longint'({32'h0, BASE}) + 4 * DEPTH) || (addr % 4 != 0);
  endfunction

  function automatic int model_index(input logic [31:0] addr);
    return int'((longint'({32'h0, addr}) - longint'({32'h0, BASE})) / 4);
  endfunction

  function automatic logic pick_ready(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) return ($urandom_range(0, 1) == 1);
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  task automatic countFailure(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got timeout/unexpected, expected normal progress (cycle %0d)", name, cycle);
  endtask

  // Response-ready driver changes away from the sampling edge.
  initial begin
    bus_a.resp_ready = 1'b0;
    bus_b.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus_a.resp_ready = pick_ready(rr_mode[0]);
      bus_b.resp_ready = pick_ready(rr_mode[1]);
    end
  end

  task automatic monitorDut(input int k, input logic rv, input logic rr, input logic rq,
                            input logic [31:0] rd, input logic re);
    if (reset) begin
      in_resp[k] = 1'b0;
      post_hs[k] = 1'b0;
      return;
    end
    if (post_hs[k]) begin
      post_hs[k] = 1'b0;
      checkOutput($sformatf("idle_valid%0d", k), {31'd0, rv}, 32'd0);
      checkOutput($sformatf("idle_ready%0d", k), {31'd0, rq}, 32'd1);
      checkOutput($sformatf("idle_rdata%0d", k), rd, 32'd0);
      checkOutput($sformatf("idle_err%0d", k), {31'd0, re}, 32'd0);
    end
    if (rv) begin
      if (!in_resp[k]) begin
        in_resp[k] = 1'b1;
        if ((k == 0 && exp_q_a.size() == 0) || (k == 1 && exp_q_b.size() == 0)) begin
          countFailure($sformatf("unexpected_resp%0d", k));
          cur[k].rdata = rd;
          cur[k].err = re;
          cur[k].accept_cycle = cycle - ws(k) - 1;
        end else begin
          cur[k] = (k == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
          checkOutput($sformatf("latency%0d", k), cycle, cur[k].accept_cycle + ws(k) + 1);
        end
        checkOutput($sformatf("rdata%0d", k), rd, cur[k].rdata);
        checkOutput($sformatf("err%0d", k), {31'd0, re}, {31'd0, cur[k].err});
      end else begin
        checkOutput($sformatf("hold_rdata%0d", k), rd, cur[k].rdata);
        checkOutput($sformatf("hold_err%0d", k), {31'd0, re}, {31'd0, cur[k].err});
      end
      checkOutput($sformatf("busy_ready%0d", k), {31'd0, rq}, 32'd0);
      if (rr) begin
        in_resp[k] = 1'b0;
        post_hs[k] = 1'b1;
        hs_cycle[k] = cycle + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    monitorDut(0, bus_a.resp_valid, bus_a.resp_ready, bus_a.req_ready, bus_a.resp_rdata, bus_a.resp_err);
    monitorDut(1, bus_b.resp_valid, bus_b.resp_ready, bus_b.req_ready, bus_b.resp_rdata, bus_b.resp_err);
  end

  task automatic driveReq(input int k, input logic v, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    if (k == 0) begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
    end else begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wdata;
    end
  endtask

  // Issue one request; the expected response goes to the scoreboard unless aborted.
  task automatic applyStimulus(input int k, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit abort, output int acc);
    bit   ok;
    logic rdy;
    exp_t e;
    int   idx;
    ok = 1'b0;
    @(negedge clk);
    driveReq(k, 1'b1, we, addr, wdata);
    for (int t = 0; t < 100; t++) begin
      rdy = (k == 0) ? bus_a.req_ready : bus_b.req_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    acc = cycle;
    driveReq(k, 1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom);
    if (!ok) begin
      countFailure($sformatf("accept_timeout%0d", k));
    end else if (!abort) begin
      e.err = model_err(addr);
      e.rdata = 32'd0;
      e.accept_cycle = acc;
      if (!e.err) begin
        idx = model_index(addr);
        if (we) model_mem[k][idx] = wdata;
        else e.rdata = model_mem[k][idx];
      end
      if (k == 0) exp_q_a.push_back(e);
      else exp_q_b.push_back(e);
    end
  endtask

  task automatic waitIdle(input int k);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (((k == 0) ? exp_q_a.size() : exp_q_b.size()) == 0 && !in_resp[k] && !post_hs[k]) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) countFailure($sformatf("drain_timeout%0d", k));
  endtask

  function automatic logic [31:0] random_addr();
    int c;
    c = $urandom_range(0, 9);
    if (c <= 6) return BASE + 32'(4 * $urandom_range(0, 15));
    if (c == 7) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
    if (c == 8) return ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 999));
    return ($urandom_range(0, 1) == 1) ? 32'h0 : BASE - 32'(4 * $urandom_range(1, 999));
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          acc;
    int          acc_b0;
    int          acc_b1;
    bit          seen;
    logic [31:0] err_addr [6];
    logic        err_we [6];
    logic [31:0] err_data [6];

    err_addr = '{32'h1000_0002, 32'h1000_03FC, 32'h1000_0400, 32'h1000_03FC, 32'hFFFF_FFFC, 32'h0FFF_FFFC};
    err_we   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    err_data = '{32'h0, 32'hA5A5_5A5A, 32'hBAD0_0001, 32'h0, 32'h0, 32'hBAD0_0002};

    rr_mode[0] = 0;
    rr_mode[1] = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) model_mem[k][i] = 32'd0;
    end
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    driveReq(1, 1'b0, 1'b0, 32'd0, 32'd0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready_a", {31'd0, bus_a.req_ready}, 32'd1);
    checkOutput("rst_valid_a", {31'd0, bus_a.resp_valid}, 32'd0);
    checkOutput("rst_rdata_a", bus_a.resp_rdata, 32'd0);
    checkOutput("rst_err_a", {31'd0, bus_a.resp_err}, 32'd0);
    checkOutput("rst_ready_b", {31'd0, bus_b.req_ready}, 32'd1);
    checkOutput("rst_valid_b", {31'd0, bus_b.resp_valid}, 32'd0);
    checkOutput("rst_rdata_b", bus_b.resp_rdata, 32'd0);
    checkOutput("rst_err_b", {31'd0, bus_b.resp_err}, 32'd0);
    reset = 1'b0;

    // Give every word a known value regardless of RAM power-up contents.
    rr_mode[0] = 1;
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1'b1, BASE + 32'(4 * i), 32'd0, 1'b0, acc);

    applyStimulus(0, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 1'b0, acc);
    applyStimulus(0, 1'b0, 32'h1000_0008, 32'h0, 1'b0, acc);

    for (int i = 0; i < 6; i++) applyStimulus(0, err_we[i], err_addr[i], err_data[i], 1'b0, acc);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(0, $urandom_range(0, 1) == 1, random_addr(), $urandom, 1'b0, acc);
    end
    waitIdle(0);

    // Backpressure: hold the response, then release and accept again at once.
    rr_mode[0] = 2;
    applyStimulus(0, 1'b0, 32'h1000_0008, 32'h0, 1'b0, acc);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus_a.resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) countFailure("bp_resp_timeout");
    repeat (5) @(negedge clk);
    rr_mode[0] = 0;
    applyStimulus(0, 1'b1, 32'h1000_000C, $urandom, 1'b0, acc);
    checkOutput("accept_after_hs", acc - hs_cycle[0], 32'd1);
    waitIdle(0);

    // Reset lands on the very edge where the store would happen.
    applyStimulus(0, 1'b1, 32'h1000_0010, 32'h0, 1'b0, acc);
    waitIdle(0);
    applyStimulus(0, 1'b1, 32'h1000_0010, 32'h1234_5678, 1'b1, acc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", {31'd0, bus_a.req_ready}, 32'd1);
    checkOutput("abort_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(0, 1'b0, 32'h1000_0010, 32'h0, 1'b0, acc);
    waitIdle(0);

    applyStimulus(1, 1'b1, 32'h1000_0000, 32'hC0FF_EE01, 1'b0, acc);
    applyStimulus(1, 1'b1, 32'h1000_0004, 32'hC0FF_EE02, 1'b0, acc);
    applyStimulus(1, 1'b0, 32'h1000_0000, 32'h0, 1'b0, acc_b0);
    applyStimulus(1, 1'b0, 32'h1000_0004, 32'h0, 1'b0, acc_b1);
    checkOutput("b2b_spacing", acc_b1 - acc_b0, 32'd3);

    rr_mode[1] = 1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1, $urandom_range(0, 1) == 1, random_addr(), $urandom, 1'b0, acc);
    end
    rr_mode[1] = 0;
    waitIdle(1);
    waitIdle(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for CPU data accesses. Accepts one load/store request at a time over a valid/ready handshake and services it against an internal word-addressed RAM after a programmable number of wait states. Returns read data or write completion with an error flag. Sits between the CPU's data-memory port and the data segment starting at 0x10000000, replacing the fixed-latency synchronous RAM with a handshaked target.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored.
- BASE_ADDR, 32'h10000000: byte address of word 0.
- WAIT_STATES, 2: extra cycles between accept and access, 0..15.

- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  CPU accepts response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  out-of-range or misaligned request.

## Operation
- States are IDLE, WAIT and RESP. There is a 4-bit wait counter cnt. Latched request registers hold we, addr and wdata.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch we/addr/wdata, set cnt=WAIT_STATES, and go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt!=0, decrement it.
  - If cnt==0, perform the access at this edge and go to RESP.
- Access rules:
  - Word index = (addr-BASE_ADDR)>>2.
  - Error if addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH_WORDS, or addr[1:0]!=0.
  - Load: resp_rdata <= mem[index], resp_err <= 0.
  - Store: mem[index] <= wdata, resp_rdata <= 0, resp_err <= 0.
  - Error: no array write, resp_rdata <= 0, resp_err <= 1.
- RESP:
  - resp_valid=1. resp_rdata and resp_err stay stable.
  - On resp_ready at an edge, go to IDLE, clear resp_valid, and zero resp_rdata and resp_err.
- Address subtraction and range compare use 32-bit unsigned arithmetic. Addresses near 0xFFFFFFFF must not wrap into range.
- Memory contents start at zero. Reset does not clear them.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
- Reset has priority over every transition. A reset in WAIT or RESP aborts the request.
- If reset is asserted at the edge where a store would occur, the write does not happen.
- Latency: request accepted at edge N → access at edge N+WAIT_STATES+1 → resp_valid high from that edge on.
- With WAIT_STATES=0, resp_valid rises one edge after accept.
- There is no accept during WAIT or RESP. The earliest next accept is the edge after the resp_ready handshake edge, giving 1 idle cycle between transactions.
- req_valid, req_we, req_addr and req_wdata are sampled only at the accept edge. Later changes to them are ignored.
- resp_ready while resp_valid=0 is ignored.
- A load to an address stored by the previous transaction returns the new data.

## Test plan
- **Reset defaults:** assert reset for 2 cycles → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- **Store/load round trip (WAIT_STATES=2):** store 0xDEADBEEF to 0x10000008, then load 0x10000008.
  - Store: resp_valid rises 3 edges after accept, resp_err=0.
  - Load: resp_rdata=0xDEADBEEF.
- **Error cases:**
  - Load from 0x10000002 → resp_err=1, resp_rdata=0.
  - Store to BASE_ADDR+4*DEPTH_WORDS → resp_err=1, and a load of the last valid word (0x100003FC) still returns its prior value.
- **Response backpressure:** hold resp_ready=0 for 5 cycles during a load → resp_valid and resp_rdata stay stable and req_ready=0 throughout; raise resp_ready → IDLE next edge, then a new request is accepted one edge later.
- **Reset mid-store:** assert reset in WAIT during a store of 0x12345678 to 0x10000010 → subsequent load of 0x10000010 returns 0x00000000.
- **Zero wait states:** with WAIT_STATES=0, back-to-back loads of 0x10000000 and 0x10000004 → each response appears 1 edge after accept, with accept-to-accept spacing of 3 edges when resp_ready is held high.
